// File: rtl/c3lib_ckdiv_chk_pkg.sv
// ----------------------------------------------------------------------------
// c3lib_ckdiv_chk_pkg
// Shared definitions for the divided-clock checker:
//   chk_state_t  - checker FSM states (IDLE -> ACQ -> LOCKED)
//   chk_half     - half-period of the divided clock in clk_in cycles
//   chk_phase_w  - width of the phase output for a given divide ratio
//   chk_run_w    - width of the run counter (must hold HALF+1)
//   chk_good_w   - width of the good-edge counter (must hold LOCK_CNT)
// ----------------------------------------------------------------------------
package c3lib_ckdiv_chk_pkg;

   typedef enum logic [1:0] {
      CHK_IDLE   = 2'd0,
      CHK_ACQ    = 2'd1,
      CHK_LOCKED = 2'd2
   } chk_state_t;

   function automatic int chk_half(input int div_ratio);
      return div_ratio / 2;
   endfunction

   function automatic int chk_phase_w(input int div_ratio);
      return (div_ratio > 2) ? $clog2(div_ratio) : 1;
   endfunction

   // Run counter saturates at HALF+1, so it needs room for that value.
   function automatic int chk_run_w(input int div_ratio);
      return $clog2(div_ratio / 2 + 2);
   endfunction

   function automatic int chk_good_w(input int lock_cnt);
      return (lock_cnt > 1) ? $clog2(lock_cnt + 1) : 1;
   endfunction

endpackage

// File: rtl/c3lib_ckdiv_chk_edge_ctn.sv
// ----------------------------------------------------------------------------
// c3lib_ckdiv_chk_edge_ctn
// Samples the divided clock, detects edges and classifies each half-period.
//   clk_in      : reference clock, all logic on posedge
//   rst_n       : asynchronous active-low reset
//   clk_div_in  : divided clock under check (synchronous to clk_in)
//   edge_flag   : sampled level changed this cycle
//   rise_next   : a rising edge will be flagged in the next cycle
//   good_edge   : edge arrived exactly HALF cycles after the previous one
//   bad_raw     : half-period too short, or too long (reported once)
// ----------------------------------------------------------------------------
module c3lib_ckdiv_chk_edge_ctn
   import c3lib_ckdiv_chk_pkg::*;
#(
   parameter int DIV_RATIO = 2
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic clk_div_in,
   output logic edge_flag,
   output logic rise_next,
   output logic good_edge,
   output logic bad_raw
);

   localparam int HALF  = chk_half(DIV_RATIO);
   localparam int RUN_W = chk_run_w(DIV_RATIO);
   localparam logic [RUN_W-1:0] HALF_V = RUN_W'(HALF);
   localparam logic [RUN_W-1:0] SAT_V  = RUN_W'(HALF + 1);

   logic             s;
   logic             s_d;
   logic [RUN_W-1:0] run;

   // run holds the number of cycles since the last edge cycle.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         s   <= 1'b0;
         s_d <= 1'b0;
         run <= '0;
      end else begin
         s   <= clk_div_in;
         s_d <= s;
         if (edge_flag) begin
            run <= RUN_W'(1);
         end else if (run != SAT_V) begin
            run <= run + RUN_W'(1);
         end
      end
   end

   assign edge_flag = s ^ s_d;

   // Looks one cycle ahead so the phase counter reads 0 on the rise cycle.
   assign rise_next = clk_div_in & ~s;

   assign good_edge = edge_flag && (run == HALF_V);

   // A long half-period is reported on the HALF -> HALF+1 step only; the edge
   // that finally ends it arrives with run saturated and is not reported again.
   assign bad_raw = (edge_flag && (run < HALF_V)) ||
                    (!edge_flag && (run == HALF_V));

endmodule

// File: rtl/c3lib_ckdiv_chk_ctn.sv
// ----------------------------------------------------------------------------
// c3lib_ckdiv_chk_ctn
// Checks that a divided clock toggles at exactly DIV_RATIO with 50% duty.
//   clk_in      : fast reference clock
//   rst_n       : asynchronous active-low reset
//   clk_div_in  : divided clock under check
//   chk_en      : checker enable; low forces IDLE
//   err_clr     : synchronous clear of err_cnt
//   locked      : checker FSM is in LOCKED
//   err_pulse   : one-cycle pulse per bad event
//   err_cnt     : saturating count of bad events
//   phase       : position within the divided period (0 on rise), 0 unless locked
// ----------------------------------------------------------------------------
module c3lib_ckdiv_chk_ctn
   import c3lib_ckdiv_chk_pkg::*;
#(
   parameter  int DIV_RATIO = 2,
   parameter  int LOCK_CNT  = 4,
   parameter  int ERR_W     = 8,
   localparam int PHASE_W   = chk_phase_w(DIV_RATIO)
) (
   input  logic               clk_in,
   input  logic               rst_n,
   input  logic               clk_div_in,
   input  logic               chk_en,
   input  logic               err_clr,
   output logic               locked,
   output logic               err_pulse,
   output logic [ERR_W-1:0]   err_cnt,
   output logic [PHASE_W-1:0] phase
);

   localparam int GOOD_W = chk_good_w(LOCK_CNT);
   localparam logic [GOOD_W-1:0]  LOCK_LAST = GOOD_W'(LOCK_CNT - 1);
   localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(DIV_RATIO - 1);
   localparam logic [ERR_W-1:0]   ERR_MAX   = '1;

   logic edge_flag;
   logic rise_next;
   logic good_edge;
   logic bad_raw;

   chk_state_t          state;
   chk_state_t          state_nxt;
   logic [GOOD_W-1:0]   good_cnt;
   logic [GOOD_W-1:0]   good_nxt;
   logic                bad_evt;
   logic [PHASE_W-1:0]  phase_cnt;

   c3lib_ckdiv_chk_edge_ctn #(
      .DIV_RATIO (DIV_RATIO)
   ) u_edge (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .clk_div_in (clk_div_in),
      .edge_flag  (edge_flag),
      .rise_next  (rise_next),
      .good_edge  (good_edge),
      .bad_raw    (bad_raw)
   );

   // The first edge seen from IDLE only starts acquisition, so nothing is
   // judged until the FSM has left IDLE.
   always_comb begin
      state_nxt = state;
      good_nxt  = good_cnt;
      bad_evt   = chk_en && (state != CHK_IDLE) && bad_raw;
      if (!chk_en) begin
         state_nxt = CHK_IDLE;
         good_nxt  = '0;
      end else begin
         case (state)
            CHK_IDLE: begin
               if (edge_flag) begin
                  state_nxt = CHK_ACQ;
                  good_nxt  = '0;
               end
            end
            CHK_ACQ: begin
               if (bad_evt) begin
                  good_nxt = '0;
               end else if (good_edge) begin
                  if (good_cnt == LOCK_LAST) begin
                     state_nxt = CHK_LOCKED;
                     good_nxt  = '0;
                  end else begin
                     good_nxt = good_cnt + GOOD_W'(1);
                  end
               end
            end
            CHK_LOCKED: begin
               if (bad_evt) begin
                  state_nxt = CHK_ACQ;
                  good_nxt  = '0;
               end
            end
            default: begin
               state_nxt = CHK_IDLE;
               good_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state    <= CHK_IDLE;
         good_cnt <= '0;
         locked   <= 1'b0;
      end else begin
         state    <= state_nxt;
         good_cnt <= good_nxt;
         locked   <= (state_nxt == CHK_LOCKED);
      end
   end

   // Free-running phase, realigned on every rise; only exposed while locked.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         phase_cnt <= '0;
      end else if (rise_next || (phase_cnt == PHASE_MAX)) begin
         phase_cnt <= '0;
      end else begin
         phase_cnt <= phase_cnt + PHASE_W'(1);
      end
   end

   assign phase = locked ? phase_cnt : '0;

   // A bad event coinciding with err_clr leaves exactly that one event counted.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         err_pulse <= 1'b0;
         err_cnt   <= '0;
      end else begin
         err_pulse <= bad_evt;
         if (bad_evt) begin
            if (err_clr) begin
               err_cnt <= ERR_W'(1);
            end else if (err_cnt != ERR_MAX) begin
               err_cnt <= err_cnt + ERR_W'(1);
            end
         end else if (err_clr) begin
            err_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_c3lib_ckdiv_chk_ctn.sv
// ----------------------------------------------------------------------------
// tb_c3lib_ckdiv_chk_ctn
// Drives a divided clock (nominal, stretched, stuck, glitched and random) into
// the checker with DIV_RATIO=4, LOCK_CNT=4, ERR_W=2. A timestamp-based model
// predicts every cycle's outputs into a queue; a monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_c3lib_ckdiv_chk_ctn;

   localparam int DIV     = 4;
   localparam int HALF    = DIV / 2;
   localparam int LCK     = 4;
   localparam int EW      = 2;
   localparam int PW      = 2;
   localparam int ERR_MAX = (1 << EW) - 1;

   logic          clk_in = 1'b0;
   logic          rst_n;
   logic          clk_div_in;
   logic          chk_en;
   logic          err_clr;
   logic          locked;
   logic          err_pulse;
   logic [EW-1:0] err_cnt;
   logic [PW-1:0] phase;

   typedef struct packed {
      logic          lk;
      logic          pulse;
      logic [EW-1:0] cnt;
      logic [PW-1:0] ph;
   } exp_t;

   exp_t exp_q[$];

   int  n_cmp = 0;
   int  n_bad = 0;
   bit  mon_en = 1'b0;

   // Model state: timestamps of the last edge and last rise, in cycles.
   int   m_p;
   int   m_last_edge;
   int   m_last_rise;
   int   m_mode;
   int   m_good;
   int   m_errc;
   logic m_xcur;
   logic m_xprev;
   logic gen_lvl = 1'b0;
   bit   clr_on_bad = 1'b0;
   bit   clr_once = 1'b0;

   c3lib_ckdiv_chk_ctn #(
      .DIV_RATIO (DIV),
      .LOCK_CNT  (LCK),
      .ERR_W     (EW)
   ) dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .clk_div_in (clk_div_in),
      .chk_en     (chk_en),
      .err_clr    (err_clr),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .err_cnt    (err_cnt),
      .phase      (phase)
   );

   always #5 clk_in = ~clk_in;

   task automatic modelReset();
      m_p         = 0;
      m_last_edge = -1000;
      m_last_rise = 0;
      m_mode      = 0;
      m_good      = 0;
      m_errc      = 0;
      m_xcur      = 1'b0;
      m_xprev     = 1'b0;
   endtask

   // Called at a negedge: judges the cycle now in progress, predicts the
   // outputs of the next cycle and drives the inputs for the next posedge.
   task automatic applyStimulus(input logic en, input logic clr, input logic xn);
      logic edge_c;
      logic good_c;
      logic bad_c;
      logic clr_eff;
      int   gap;
      exp_t e;
      edge_c = (m_xcur != m_xprev);
      gap    = m_p - m_last_edge;
      good_c = edge_c && (gap == HALF);
      bad_c  = en && (m_mode != 0) &&
               ((edge_c && (gap < HALF)) || (!edge_c && (gap == HALF)));
      clr_eff = clr | clr_once;
      clr_once = 1'b0;
      if (clr_on_bad && bad_c) begin
         clr_eff    = 1'b1;
         clr_on_bad = 1'b0;
      end
      if (!en) begin
         m_mode = 0;
         m_good = 0;
      end else begin
         case (m_mode)
            0: if (edge_c) begin
                  m_mode = 1;
                  m_good = 0;
               end
            1: if (bad_c) begin
                  m_good = 0;
               end else if (good_c) begin
                  m_good++;
                  if (m_good == LCK) begin
                     m_mode = 2;
                     m_good = 0;
                  end
               end
            2: if (bad_c) begin
                  m_mode = 1;
                  m_good = 0;
               end
            default: ;
         endcase
      end
      if (bad_c) begin
         m_errc = clr_eff ? 1 : ((m_errc < ERR_MAX) ? m_errc + 1 : m_errc);
      end else if (clr_eff) begin
         m_errc = 0;
      end
      if (edge_c) m_last_edge = m_p;
      m_xprev = m_xcur;
      m_xcur  = xn;
      m_p++;
      if (m_xcur && !m_xprev) m_last_rise = m_p;
      e.lk    = (m_mode == 2);
      e.pulse = bad_c;
      e.cnt   = EW'(m_errc);
      e.ph    = (m_mode == 2) ? PW'((m_p - m_last_rise) % DIV) : '0;
      exp_q.push_back(e);
      chk_en     = en;
      err_clr    = clr_eff;
      clk_div_in = xn;
   endtask

   task automatic checkValue(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      exp_t a;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("[TB] FAIL scoreboard_empty: DUT output with no expectation at %0t", $time);
      end else begin
         e = exp_q.pop_front();
         a.lk    = locked;
         a.pulse = err_pulse;
         a.cnt   = err_cnt;
         a.ph    = phase;
         if (a !== e) begin
            n_bad++;
            $display("[TB] FAIL scoreboard at %0t: got locked=%0b pulse=%0b cnt=%0d phase=%0d, expected locked=%0b pulse=%0b cnt=%0d phase=%0d",
                     $time, a.lk, a.pulse, a.cnt, a.ph, e.lk, e.pulse, e.cnt, e.ph);
         end
      end
   endtask

   task automatic checkReset(input string tag);
      checkValue({tag, "_locked"}, int'(locked), 0);
      checkValue({tag, "_pulse"}, int'(err_pulse), 0);
      checkValue({tag, "_errcnt"}, int'(err_cnt), 0);
      checkValue({tag, "_phase"}, int'(phase), 0);
   endtask

   // Each half toggles the generated level and holds it; one half may be
   // given a different length to stretch, shorten or stick the clock.
   task automatic drivePeriods(input int halves, input int fault_at,
                               input int fault_len, input logic en);
      for (int h = 0; h < halves; h++) begin
         int len;
         len = (h == fault_at) ? fault_len : HALF;
         gen_lvl = ~gen_lvl;
         for (int c = 0; c < len; c++) begin
            @(negedge clk_in);
            applyStimulus(en, 1'b0, gen_lvl);
         end
      end
   endtask

   task automatic releaseReset();
      @(negedge clk_in);
      rst_n = 1'b1;
      modelReset();
      mon_en = 1'b1;
      applyStimulus(1'b1, 1'b0, gen_lvl);
   endtask

   task automatic sampleNow();
      @(posedge clk_in);
      #2;
   endtask

   initial begin
      forever begin
         @(posedge clk_in);
         #1;
         if (mon_en) checkOutput();
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n      = 1'b1;
      chk_en     = 1'b0;
      err_clr    = 1'b0;
      clk_div_in = 1'b0;
      modelReset();
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk_in);
      #1 checkReset("reset_initial");
      releaseReset();

      $display("[TB] nominal lock");
      drivePeriods(12, -1, 0, 1'b1);
      sampleNow();
      checkValue("lock_nominal", int'(locked), 1);
      checkValue("errcnt_nominal", int'(err_cnt), 0);

      $display("[TB] stretched high phase");
      drivePeriods(14, 2, 3, 1'b1);
      sampleNow();
      checkValue("relock_after_stretch", int'(locked), 1);
      checkValue("errcnt_stretch", int'(err_cnt), 1);

      $display("[TB] stuck clock");
      drivePeriods(1, 0, 10, 1'b1);
      sampleNow();
      checkValue("unlock_stuck", int'(locked), 0);
      checkValue("errcnt_stuck", int'(err_cnt), 2);
      drivePeriods(12, -1, 0, 1'b1);

      $display("[TB] glitches to saturation");
      for (int g = 0; g < 5; g++) drivePeriods(4, 1, 1, 1'b1);
      sampleNow();
      checkValue("errcnt_saturated", int'(err_cnt), ERR_MAX);
      clr_on_bad = 1'b1;
      drivePeriods(4, 1, 1, 1'b1);
      sampleNow();
      checkValue("errcnt_clr_with_bad", int'(err_cnt), 1);
      clr_once = 1'b1;
      drivePeriods(4, -1, 0, 1'b1);
      sampleNow();
      checkValue("errcnt_clr_alone", int'(err_cnt), 0);

      $display("[TB] enable dropped in acquisition");
      drivePeriods(2, 0, 1, 1'b1);
      drivePeriods(3, -1, 0, 1'b0);
      sampleNow();
      checkValue("unlock_disabled", int'(locked), 0);
      checkValue("errcnt_kept_disabled", int'(err_cnt), 1);
      drivePeriods(12, -1, 0, 1'b1);
      sampleNow();
      checkValue("lock_before_reset", int'(locked), 1);

      $display("[TB] reset while locked");
      @(negedge clk_in);
      #2 rst_n = 1'b0;
      mon_en = 1'b0;
      exp_q.delete();
      #1 checkReset("reset_async");
      repeat (2) @(negedge clk_in);
      releaseReset();
      drivePeriods(12, -1, 0, 1'b1);
      sampleNow();
      checkValue("relock_after_reset", int'(locked), 1);

      $display("[TB] randomized clock");
      for (int i = 0; i < 150; i++) begin
         int   r;
         int   len;
         logic en;
         r   = $urandom_range(0, 19);
         len = (r == 0) ? 1 : (r == 1) ? 3 : (r == 2) ? $urandom_range(4, 8) : HALF;
         en  = ($urandom_range(0, 29) != 0);
         if ($urandom_range(0, 24) == 0) clr_once = 1'b1;
         if ($urandom_range(0, 9) == 0) clr_on_bad = 1'b1;
         drivePeriods(1, 0, len, en);
      end

      sampleNow();
      checkValue("scoreboard_drained", exp_q.size(), 0);
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
